// File: rtl/usb_cdc_echo_soc.sv
// usb_cdc_echo_soc -- TinyFPGA-BX USB CDC-ACM echo SoC.
//
// Every byte the host writes to the bulk OUT endpoint is passed through a
// character transform and queued in a FIFO_DEPTH-byte FIFO for return on the
// bulk IN endpoint. The transform swaps letter case and rotates digits
// ('0'..'8' -> +1, '9' -> '0'). All other bytes are returned unchanged.
//
// Ports
//   clk    in   16 MHz board clock; also the application clock
//   rst    in   synchronous active-high reset (tie 0 on the board)
//   led    out  status LED (follows configured_o)
//   usb_p  io   USB D+
//   usb_n  io   USB D-
//   usb_pu out  D+ 1.5k pull-up enable
//
// Optional build macro: USB_CDC_SOC_HEARTBEAT_EN. When it is defined, the LED
// blinks from the top bit of an LED_DIV_BITS counter while the device is
// configured. When it is undefined, the LED is steady.
//
// This file also holds two small modules so that it elaborates on its own:
// - usb_cdc_echo_pll: stands in for the 16->48 MHz PLL.
// - usb_cdc: a pin-level stand-in for the CDC core with the same port list.
// The stand-in core uses a simplified bit-level link:
// - Host to device, one symbol per clock:
//   - usb_n=1 is a data bit (value on usb_p, LSB first).
//   - (usb_p,usb_n)=(1,0) is an IN request.
//   - (0,0) is idle.
// - Device replies after one turnaround cycle:
//   - ACK/NAK for OUT as (1,0)/(0,1).
//   - For IN, a valid flag, then 8 data bits LSB first.
// On the board build, replace both stand-ins with the real PLL and core.

module usb_cdc_echo_soc #(
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned POR_CYCLES   = 4096,
  parameter int unsigned LED_DIV_BITS = 23
) (
  input  logic clk,
  input  logic rst,
  output logic led,
  inout  wire  usb_p,
  inout  wire  usb_n,
  output logic usb_pu
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(POR_CYCLES + 1);

  // ---------------- clock / reset ----------------
  logic clk_48, pll_lock;
  usb_cdc_echo_pll u_pll (.clk_i(clk), .rst_i(rst), .clk_o(clk_48), .lock_o(pll_lock));

  logic [PW-1:0] por_cnt_q;
  logic          rst_int;

  always_ff @(posedge clk) begin
    if (rst || !pll_lock)                   por_cnt_q <= '0;
    else if (por_cnt_q != PW'(POR_CYCLES)) por_cnt_q <= por_cnt_q + 1'b1;
  end
  assign rst_int = rst | ~pll_lock | (por_cnt_q < PW'(POR_CYCLES));

  // The core lives on the 48 MHz clock, so its reset is resynchronised there.
  logic [1:0] rstn_sync_q;
  always_ff @(posedge clk_48) rstn_sync_q <= {rstn_sync_q[0], ~rst_int};

  // ---------------- USB core ----------------
  logic [7:0] out_data, in_data;
  logic       out_valid, out_ready, in_valid, in_ready, configured;
  logic       tx_en, dp_tx, dn_tx, dp_pu;

  usb_cdc u_cdc (
    .clk_i       (clk_48),
    .rstn_i      (rstn_sync_q[1]),
    .app_clk_i   (clk),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .configured_o(configured),
    .dp_pu_o     (dp_pu),
    .tx_en_o     (tx_en),
    .dp_tx_o     (dp_tx),
    .dn_tx_o     (dn_tx),
    .dp_rx_i     (usb_p),
    .dn_rx_i     (usb_n)
  );

  assign usb_p  = tx_en ? dp_tx : 1'bz;
  assign usb_n  = tx_en ? dn_tx : 1'bz;
  assign usb_pu = dp_pu;

  // ---------------- echo FIFO ----------------
  function automatic logic [7:0] xform(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A)      return c + 8'h20;
    else if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
    else if (c >= 8'h30 && c <= 8'h38) return c + 8'h01;
    else if (c == 8'h39)               return 8'h30;
    return c;
  endfunction

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop, fifo_full, fifo_empty;

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign out_ready  = ~fifo_full  & ~rst_int;
  assign in_valid   = ~fifo_empty & ~rst_int;
  assign in_data    = mem_q[rd_ptr_q];
  assign push       = out_valid & out_ready;
  assign pop        = in_valid & in_ready;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_int) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= xform(out_data);
  end

  // ---------------- LED ----------------
  logic [1:0] cfg_sync_q;
  always_ff @(posedge clk) begin
    if (rst_int) cfg_sync_q <= '0;
    else         cfg_sync_q <= {cfg_sync_q[0], configured};
  end

`ifdef USB_CDC_SOC_HEARTBEAT_EN
  logic [LED_DIV_BITS-1:0] led_cnt_q;
  always_ff @(posedge clk) begin
    if (rst_int) led_cnt_q <= '0;
    else         led_cnt_q <= led_cnt_q + 1'b1;
  end
  assign led = cfg_sync_q[1] & led_cnt_q[LED_DIV_BITS-1];
`else
  assign led = cfg_sync_q[1];
`endif

endmodule

// usb_cdc_echo_pll -- stand-in for the 16->48 MHz PLL.
// It passes the clock straight through and reports lock 7 cycles after reset.
//   clk_i in, rst_i in (sync, active high), clk_o out, lock_o out
module usb_cdc_echo_pll (
  input  logic clk_i,
  input  logic rst_i,
  output logic clk_o,
  output logic lock_o
);
  logic [2:0] lock_cnt_q;
  assign clk_o  = clk_i;
  assign lock_o = (lock_cnt_q == 3'd7);
  always_ff @(posedge clk_i) begin
    if (rst_i)        lock_cnt_q <= '0;
    else if (!lock_o) lock_cnt_q <= lock_cnt_q + 1'b1;
  end
endmodule

// usb_cdc -- pin-level stand-in for the CDC-ACM core.
// It has the same byte-stream ports as the real core.
//   Clocks and reset: clk_i (USB clock), rstn_i (sync, active low), app_clk_i.
//   OUT stream: out_data_o, out_valid_o, out_ready_i. The byte is offered for
//     one cycle; if it is refused, it is NAKed and the host resends it.
//   IN stream: in_data_i, in_valid_i, in_ready_o.
//   Status: configured_o, dp_pu_o.
//   Pins: tx_en_o, dp_tx_o, dn_tx_o, dp_rx_i, dn_rx_i.
module usb_cdc (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       app_clk_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       configured_o,
  output logic       dp_pu_o,
  output logic       tx_en_o,
  output logic       dp_tx_o,
  output logic       dn_tx_o,
  input  logic       dp_rx_i,
  input  logic       dn_rx_i
);
  typedef enum logic [2:0] {
    S_IDLE, S_TURN_OUT, S_OUT, S_TURN_IN, S_IN_FLAG, S_IN_DATA
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_q, bit_d;
  logic       cfg_q, cfg_d, pu_q;

  always_ff @(posedge clk_i) pu_q <= rstn_i;
  assign dp_pu_o      = pu_q;
  assign configured_o = cfg_q;
  assign out_data_o   = sr_q;

  always_ff @(posedge app_clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      cfg_q   <= cfg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_d       = bit_q;
    cfg_d       = cfg_q;
    out_valid_o = 1'b0;
    in_ready_o  = 1'b0;
    tx_en_o     = 1'b0;
    dp_tx_o     = 1'b0;
    dn_tx_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dn_rx_i) begin
          sr_d  = {dp_rx_i, sr_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_TURN_OUT;
        end else if (dp_rx_i) begin
          state_d = S_TURN_IN;
        end
      end
      S_TURN_OUT: state_d = S_OUT;
      S_OUT: begin
        out_valid_o = 1'b1;
        tx_en_o     = 1'b1;
        dp_tx_o     = out_ready_i;
        dn_tx_o     = ~out_ready_i;
        cfg_d       = 1'b1;
        state_d     = S_IDLE;
      end
      S_TURN_IN: state_d = S_IN_FLAG;
      S_IN_FLAG: begin
        tx_en_o    = 1'b1;
        dp_tx_o    = in_valid_i;
        dn_tx_o    = ~in_valid_i;
        in_ready_o = 1'b1;
        cfg_d      = 1'b1;
        if (in_valid_i) begin
          sr_d    = in_data_i;
          bit_d   = '0;
          state_d = S_IN_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IN_DATA: begin
        tx_en_o = 1'b1;
        dp_tx_o = sr_q[0];
        dn_tx_o = ~sr_q[0];
        sr_d    = {1'b0, sr_q[7:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_usb_cdc_echo_soc.sv
// Bench for usb_cdc_echo_soc: drives the simplified pin link as the host and
// checks echoed bytes against a queue-based reference model.
module tb_usb_cdc_echo_soc;
  localparam int DEPTH = 32;
  localparam int POR   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led, usb_pu;
  wire  usb_p, usb_n;
  logic host_en = 1'b1, host_p = 1'b0, host_n = 1'b0;

  assign usb_p = host_en ? host_p : 1'bz;
  assign usb_n = host_en ? host_n : 1'bz;

  always #5 clk = ~clk;

  usb_cdc_echo_soc #(.FIFO_DEPTH(DEPTH), .POR_CYCLES(POR), .LED_DIV_BITS(4)) dut (
    .clk(clk), .rst(rst), .led(led), .usb_p(usb_p), .usb_n(usb_n), .usb_pu(usb_pu)
  );

  int total = 0;
  int bad   = 0;
  byte unsigned model_q[$];

  typedef struct {
    byte unsigned din;
    byte unsigned dexp;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Case flip is bit 5 for letters; digits rotate modulo 10.
  function automatic byte unsigned ref_xf(input byte unsigned c);
    if (c inside {[8'h41:8'h5A]} || c inside {[8'h61:8'h7A]}) return c ^ 8'h20;
    if (c inside {[8'h30:8'h39]}) return byte'(8'h30 + ((c - 8'h30 + 1) % 10));
    return c;
  endfunction

  task automatic host_out(input byte unsigned b, output bit ack);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); host_p = b[i]; host_n = 1'b1;
    end
    @(negedge clk); host_en = 1'b0; host_p = 1'b0; host_n = 1'b0;
    @(negedge clk); ack = (usb_p === 1'b1) && (usb_n === 1'b0);
    @(negedge clk); host_en = 1'b1;
  endtask

  task automatic host_in(output bit vld, output byte unsigned d);
    d = 8'h00;
    @(negedge clk); host_p = 1'b1; host_n = 1'b0;
    @(negedge clk); host_en = 1'b0; host_p = 1'b0;
    @(negedge clk); vld = (usb_p === 1'b1);
    if (vld) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk); d[i] = (usb_p === 1'b1);
      end
    end
    @(negedge clk); host_en = 1'b1;
  endtask

  task automatic send(input byte unsigned b, input string name);
    bit ack, exp_ack;
    exp_ack = (model_q.size() < DEPTH);
    host_out(b, ack);
    check({name, "_ack"}, int'(ack), int'(exp_ack));
    if (exp_ack) model_q.push_back(ref_xf(b));
  endtask

  task automatic recv(input string name);
    bit vld;
    byte unsigned d;
    host_in(vld, d);
    check({name, "_vld"}, int'(vld), int'(model_q.size() != 0));
    if (model_q.size() != 0) check({name, "_dat"}, int'(d), int'(model_q.pop_front()));
  endtask

  task automatic power_up(input string name);
    bit vld;
    byte unsigned d;
    time t0;
    int cyc;
    host_en = 1'b1; host_p = 1'b0; host_n = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    t0 = $time;
    model_q.delete();
    @(negedge clk);
    check({name, "_pu_low"}, int'(usb_pu), 0);
    check({name, "_led_low"}, int'(led), 0);
    host_in(vld, d);
    check({name, "_in_in_reset"}, int'(vld), 0);
    while (usb_pu !== 1'b1 && ($time - t0) < (POR + 100) * 10) @(negedge clk);
    cyc = int'(($time - t0) / 10);
    check({name, "_pu_up"}, int'(usb_pu === 1'b1), 1);
    check({name, "_pu_after_por"}, int'(cyc >= POR && cyc <= POR + 16), 1);
    repeat (4) @(negedge clk);
    check({name, "_led_unconfigured"}, int'(led), 0);
  endtask

  initial begin
    bit vld, ack;
    byte unsigned d;
    string s;

    tbl[0]  = '{8'h41, 8'h61};  tbl[1]  = '{8'h5A, 8'h7A};
    tbl[2]  = '{8'h61, 8'h41};  tbl[3]  = '{8'h7A, 8'h5A};
    tbl[4]  = '{8'h30, 8'h31};  tbl[5]  = '{8'h38, 8'h39};
    tbl[6]  = '{8'h39, 8'h30};  tbl[7]  = '{8'h40, 8'h40};
    tbl[8]  = '{8'h5B, 8'h5B};  tbl[9]  = '{8'h60, 8'h60};
    tbl[10] = '{8'h7B, 8'h7B};  tbl[11] = '{8'h2F, 8'h2F};
    tbl[12] = '{8'h3A, 8'h3A};  tbl[13] = '{8'h01, 8'h01};
    tbl[14] = '{8'hFF, 8'hFF};  tbl[15] = '{8'h4D, 8'h6D};

    power_up("por");

    // Transform table, one byte round trip at a time.
    for (int i = 0; i < 16; i++) begin
      host_out(tbl[i].din, ack);
      check($sformatf("tbl%0d_ack", i), int'(ack), 1);
      host_in(vld, d);
      check($sformatf("tbl%0d_vld", i), int'(vld), 1);
      check($sformatf("tbl%0d_dat", i), int'(d), int'(tbl[i].dexp));
      if (i == 0) check("led_configured", int'(led), 1);
    end
    host_in(vld, d);
    check("empty_nak", int'(vld), 0);

    // 01..07 then drain, plus one extra IN that must NAK.
    for (int i = 1; i <= 7; i++) send(byte'(i), "seq7");
    for (int i = 0; i < 8; i++) recv("seq7_in");

    // 21..28 followed by "12345678".
    for (int i = 0; i < 8; i++) send(byte'(8'h21 + i), "seq16");
    s = "12345678";
    for (int i = 0; i < s.len(); i++) send(s[i], "seq16");
    for (int i = 0; i < 17; i++) recv("seq16_in");

    s = "ABCDEFGHQRSTUVWXabcd";
    for (int i = 0; i < s.len(); i++) send(s[i], "case");
    for (int i = 0; i < 21; i++) recv("case_in");

    // Overfill: the last 8 bytes must NAK; resend them after a partial drain.
    for (int i = 0; i < DEPTH + 8; i++) send(byte'(8'h80 + i), "fill");
    check("fill_level", model_q.size(), DEPTH);
    for (int i = 0; i < 8; i++) recv("fill_drain");
    for (int i = DEPTH; i < DEPTH + 8; i++) send(byte'(8'h80 + i), "refill");
    for (int i = 0; i < DEPTH + 1; i++) recv("refill_drain");

    // Random mix of OUT and IN, including full and empty edges.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 55) send(byte'($urandom_range(0, 255)), "rnd_out");
      else                            recv("rnd_in");
    end
    while (model_q.size() != 0) recv("rnd_drain");
    recv("rnd_final");

    // Reset mid-transfer drops queued bytes and the configured state.
    for (int i = 0; i < 5; i++) send(byte'(8'h41 + i), "pre_rst");
    power_up("rerst");
    host_in(vld, d);
    check("rerst_fifo_empty", int'(vld), 0);
    send(8'h39, "post_rst");
    recv("post_rst_in");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
